ddr4_v2_2_20_pipe_comparator: RTL and testbench
===============================================

# ddr4_v2_2_20_pipe_comparator

Parametrised, pipelined, multi-channel comparator for the AXI upsizer and address-path logic. It compares one shared operand B against C_NUM_CH operands A using a segmented carry chain of 3-bit segments, with per-transaction mode and bit mask. Results pass through a valid/ready pipeline whose depth is set by how many segments are evaluated per register stage. Per-channel results are reduced to an any-hit flag and the lowest hit index.

## Interface
- C_FAMILY, "virtex6": target family; passed to the segment sub-module.
- C_DATA_WIDTH, 32: operand width per channel, ≥1.
- C_NUM_CH, 4: number of A channels, ≥1.
- C_LUTS_PER_STAGE, 2: 3-bit segments evaluated per pipeline stage, ≥1.
- ACLK  in  1  clock; all logic on the rising edge.
- ARESETN  in  1  asynchronous, active-low reset.
- S_VALID  in  1  request valid.
- S_READY  out  1  request accepted when S_VALID & S_READY.
- S_A  in  C_NUM_CH*C_DATA_WIDTH  channel operands; channel k is at bits [k*W +: W].
- S_B  in  C_DATA_WIDTH  shared operand.
- S_MASK  in  C_DATA_WIDTH  1 = bit participates; 0 = bit forced equal.
- S_MODE  in  2  00 EQ, 01 NE, 10 LT, 11 GE (unsigned).
- S_CIN  in  1  chain carry-in.
- M_VALID  out  1  result valid.
- M_READY  in  1  result consumed when M_VALID & M_READY.
- M_MATCH  out  C_NUM_CH  per-channel result.
- M_ANY  out  1  OR of M_MATCH.
- M_INDEX  out  max(1,clog2(C_NUM_CH))  lowest k with M_MATCH[k]=1; 0 if none.

## Operation
- NUM_LUT = ceil(W/3). Operands are zero-padded at the MSB to NUM_LUT*3; padding applies to A, B and MASK.
- Per segment j, on the masked bits: eq_j = (a_j == b_j); lt_j = (a_j < b_j).
- Chains run from segment 0 (LSB) upward, starting from c_0 = S_CIN:
  - EQ/NE: c_{j+1} = c_j & eq_j.
  - LT/GE: c_{j+1} = lt_j | (eq_j & c_j). With CIN=1, LT gives LE and GE gives GT.
- Final result: EQ = c_N; NE = ~c_N; LT = c_N; GE = ~c_N.
- NUM_STAGES = ceil(NUM_LUT / C_LUTS_PER_STAGE).
  - Stage s evaluates segments [s*L, (s+1)*L) and registers the partial carry per channel, plus the remaining operand bits, mode and valid.
  - The reduction (M_ANY, M_INDEX) is done combinationally in the last stage before its register.
- Flow control per stage: ready_s = ~valid_s | ready_{s+1}, with ready_{NUM_STAGES} = M_READY. S_READY = ready_0. This is a combinational ready path; it is intentional and has no skid.
- A stage loads when its ready is 1. Its valid becomes the upstream valid, so bubbles collapse.
- Reset while ARESETN=0: every stage valid, carry and output register clears; M_VALID=0, M_MATCH=0, M_ANY=0, M_INDEX=0, S_READY=0. In-flight transactions are discarded; the next cycle after release starts empty.

## Timing
- Latency is NUM_STAGES cycles from the accept edge to M_VALID with no backpressure. Defaults: W=32 → NUM_LUT=11 → 6 stages.
- Throughput is 1 result/cycle with M_READY held high.
- While M_VALID=1 and M_READY=0, M_* hold stable. The pipeline fills until every stage is valid, then S_READY=0.
- Accept and drain in the same cycle on a full pipeline is legal; throughput is maintained.
- S_READY is 1 one cycle after ARESETN rises.

## Structure
- Package ddr4_v2_2_20_cmp_pkg:
  - mode enum (CMP_EQ, CMP_NE, CMP_LT, CMP_GE);
  - constant C_BITS_PER_LUT = 3;
  - functions f_num_lut(W), f_num_stages(W, L), f_idx_w(N).
- Sub-module ddr4_v2_2_20_cmp_segment: one 3-bit masked slice with inputs a, b, mask, cin and mode, and output cout. It is instantiated NUM_LUT × C_NUM_CH times inside the generate loops.

## Test plan
- EQ, W=32, N=4, MASK=all 1, A={5,7,7,9}, B=7, CIN=1 → after 6 cycles M_MATCH=0110, M_ANY=1, M_INDEX=1.
- LT then GE, A0=0x0000FFFF, B=0x00010000, CIN=0 → LT=1, GE=0. Same test with A0=B and CIN=1 → LT=1 (LE), GE=0 (GT false).
- Masked EQ, A0=0xDEAD_BEEF, B=0xDEAD_0000, MASK=0xFFFF_0000 → M_MATCH[0]=1. With MASK=all 1 → 0.
- Backpressure: 10 back-to-back requests, M_READY low for cycles 3–12 → S_READY=0 after 6 accepts; results arrive in order with no loss or duplication; outputs stay stable while stalled.
- Reset mid-stream: ARESETN low with 3 in flight → M_VALID=0 and all outputs 0 immediately (async); none of the 3 emerge after release.
- W=1, N=1, L=1 corner: NUM_LUT=1, 1-stage latency, M_INDEX width 1, always 0.

Source files
------------

// File: rtl/ddr4_v2_2_20_pipe_comparator_pkg.sv
// Shared types and sizing helpers for the pipelined multi-channel comparator.
package ddr4_v2_2_20_cmp_pkg;

    typedef enum logic [1:0] {
        CMP_EQ = 2'b00,
        CMP_NE = 2'b01,
        CMP_LT = 2'b10,
        CMP_GE = 2'b11
    } cmp_mode_e;

    localparam int C_BITS_PER_LUT = 3;

    function automatic int f_num_lut(input int w);
        return (w + C_BITS_PER_LUT - 1) / C_BITS_PER_LUT;
    endfunction

    function automatic int f_num_stages(input int w, input int l);
        return (f_num_lut(w) + l - 1) / l;
    endfunction

    function automatic int f_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ddr4_v2_2_20_pipe_comparator_if.sv
// Request/result bus of the pipelined comparator; the slave side is the comparator.
interface ddr4_v2_2_20_pipe_comparator_if
    import ddr4_v2_2_20_cmp_pkg::*;
#(
    parameter int C_DATA_WIDTH = 32,
    parameter int C_NUM_CH     = 4
);
    localparam int IDX_W = f_idx_w(C_NUM_CH);

    logic                             S_VALID;
    logic                             S_READY;
    logic [C_NUM_CH*C_DATA_WIDTH-1:0] S_A;
    logic [C_DATA_WIDTH-1:0]          S_B;
    logic [C_DATA_WIDTH-1:0]          S_MASK;
    logic [1:0]                       S_MODE;
    logic                             S_CIN;
    logic                             M_VALID;
    logic                             M_READY;
    logic [C_NUM_CH-1:0]              M_MATCH;
    logic                             M_ANY;
    logic [IDX_W-1:0]                 M_INDEX;

    modport master (
        output S_VALID, S_A, S_B, S_MASK, S_MODE, S_CIN, M_READY,
        input  S_READY, M_VALID, M_MATCH, M_ANY, M_INDEX
    );

    modport slave (
        input  S_VALID, S_A, S_B, S_MASK, S_MODE, S_CIN, M_READY,
        output S_READY, M_VALID, M_MATCH, M_ANY, M_INDEX
    );

endinterface

// File: rtl/ddr4_v2_2_20_pipe_comparator_segment.sv
// One 3-bit masked slice of the comparator carry chain.
module ddr4_v2_2_20_cmp_segment
    import ddr4_v2_2_20_cmp_pkg::*;
#(
    parameter C_FAMILY = "virtex6"
) (
    input  logic [C_BITS_PER_LUT-1:0] a,
    input  logic [C_BITS_PER_LUT-1:0] b,
    input  logic [C_BITS_PER_LUT-1:0] mask,
    input  logic                      cin,
    input  cmp_mode_e                 mode,
    output logic                      cout
);

    logic [C_BITS_PER_LUT-1:0] a_m;
    logic [C_BITS_PER_LUT-1:0] b_m;
    logic                      eq;
    logic                      lt;

    always_comb begin
        a_m = a & mask;
        b_m = b & mask;
        eq  = (a_m == b_m);
        lt  = (a_m < b_m);
        // mode[1] separates the equality chains (EQ/NE) from the magnitude chains (LT/GE)
        if (mode[1]) cout = lt | (eq & cin);
        else         cout = cin & eq;
    end

endmodule

// File: rtl/ddr4_v2_2_20_pipe_comparator.sv
// Pipelined multi-channel comparator: segmented carry chains split across
// valid/ready register stages, with any-hit / lowest-index reduction at the end.
module ddr4_v2_2_20_pipe_comparator
    import ddr4_v2_2_20_cmp_pkg::*;
#(
    parameter     C_FAMILY         = "virtex6",
    parameter int C_DATA_WIDTH     = 32,
    parameter int C_NUM_CH         = 4,
    parameter int C_LUTS_PER_STAGE = 2
) (
    input logic                           ACLK,
    input logic                           ARESETN,
    ddr4_v2_2_20_pipe_comparator_if.slave cmp
);

    localparam int W     = C_DATA_WIDTH;
    localparam int N     = C_NUM_CH;
    localparam int L     = C_LUTS_PER_STAGE;
    localparam int NL    = f_num_lut(W);
    localparam int PW    = NL * C_BITS_PER_LUT;
    localparam int NS    = f_num_stages(W, L);
    localparam int IDX_W = f_idx_w(N);

    // Index s holds the inputs of stage s (port side for s = 0).
    logic          st_v    [NS];
    logic [N-1:0]  st_c    [NS];
    cmp_mode_e     st_mode [NS];
    logic [PW-1:0] st_a    [NS][N];
    logic [PW-1:0] st_b    [NS];
    logic [PW-1:0] st_m    [NS];

    logic [NS-1:0] vq_all;
    logic [NS:0]   ready;
    logic          run_q;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) run_q <= 1'b0;
        else          run_q <= 1'b1;
    end

    always_comb begin
        ready     = '0;
        ready[NS] = cmp.M_READY;
        for (int unsigned s = NS; s > 0; s--)
            ready[s-1] = ~vq_all[s-1] | ready[s];
    end

    assign cmp.S_READY = ready[0] & run_q;

    assign st_v[0]    = cmp.S_VALID & run_q;
    assign st_c[0]    = {N{cmp.S_CIN}};
    assign st_mode[0] = cmp_mode_e'(cmp.S_MODE);
    assign st_b[0]    = PW'(cmp.S_B);
    assign st_m[0]    = PW'(cmp.S_MASK);

    for (genvar k = 0; k < N; k++) begin : g_in
        assign st_a[0][k] = PW'(cmp.S_A[k*W +: W]);
    end

    for (genvar s = 0; s < NS; s++) begin : g_stage
        localparam int SEG_LO = s * L;
        localparam int SEG_HI = ((s + 1) * L < NL) ? (s + 1) * L : NL;
        localparam int NSEG   = SEG_HI - SEG_LO;

        logic [N-1:0] c_nxt;
        logic         v_q;

        for (genvar k = 0; k < N; k++) begin : g_ch
            logic [NSEG:0] chain;
            assign chain[0] = st_c[s][k];
            for (genvar j = 0; j < NSEG; j++) begin : g_seg
                localparam int LSB = (SEG_LO + j) * C_BITS_PER_LUT;
                ddr4_v2_2_20_cmp_segment #(
                    .C_FAMILY(C_FAMILY)
                ) u_seg (
                    .a    (st_a[s][k][LSB +: C_BITS_PER_LUT]),
                    .b    (st_b[s][LSB +: C_BITS_PER_LUT]),
                    .mask (st_m[s][LSB +: C_BITS_PER_LUT]),
                    .cin  (chain[j]),
                    .mode (st_mode[s]),
                    .cout (chain[j+1])
                );
            end
            assign c_nxt[k] = chain[NSEG];
        end

        always_ff @(posedge ACLK or negedge ARESETN) begin
            if (!ARESETN)      v_q <= 1'b0;
            else if (ready[s]) v_q <= st_v[s];
        end
        assign vq_all[s] = v_q;

        if (s < NS - 1) begin : g_mid
            logic [N-1:0]  c_q;
            cmp_mode_e     mode_q;
            logic [PW-1:0] a_q [N];
            logic [PW-1:0] b_q;
            logic [PW-1:0] m_q;

            always_ff @(posedge ACLK or negedge ARESETN) begin
                if (!ARESETN) begin
                    c_q    <= '0;
                    mode_q <= CMP_EQ;
                    b_q    <= '0;
                    m_q    <= '0;
                    for (int unsigned k = 0; k < N; k++) a_q[k] <= '0;
                end else if (ready[s]) begin
                    c_q    <= c_nxt;
                    mode_q <= st_mode[s];
                    b_q    <= st_b[s];
                    m_q    <= st_m[s];
                    for (int unsigned k = 0; k < N; k++) a_q[k] <= st_a[s][k];
                end
            end

            assign st_v[s+1]    = v_q;
            assign st_c[s+1]    = c_q;
            assign st_mode[s+1] = mode_q;
            assign st_b[s+1]    = b_q;
            assign st_m[s+1]    = m_q;
            for (genvar k = 0; k < N; k++) begin : g_fwd
                assign st_a[s+1][k] = a_q[k];
            end
        end else begin : g_last
            logic [N-1:0]     match_nxt;
            logic             any_nxt;
            logic [IDX_W-1:0] idx_nxt;
            logic [N-1:0]     match_q;
            logic             any_q;
            logic [IDX_W-1:0] idx_q;

            // NE and GE are the inverted chain results (mode[0] set).
            always_comb begin
                match_nxt = st_mode[s][0] ? ~c_nxt : c_nxt;
                any_nxt   = |match_nxt;
                idx_nxt   = '0;
                for (int unsigned k = N; k > 0; k--)
                    if (match_nxt[k-1]) idx_nxt = IDX_W'(k - 1);
            end

            always_ff @(posedge ACLK or negedge ARESETN) begin
                if (!ARESETN) begin
                    match_q <= '0;
                    any_q   <= 1'b0;
                    idx_q   <= '0;
                end else if (ready[s]) begin
                    match_q <= match_nxt;
                    any_q   <= any_nxt;
                    idx_q   <= idx_nxt;
                end
            end

            assign cmp.M_VALID = v_q;
            assign cmp.M_MATCH = match_q;
            assign cmp.M_ANY   = any_q;
            assign cmp.M_INDEX = idx_q;
        end
    end

endmodule

// File: tb/tb_ddr4_v2_2_20_pipe_comparator.sv
// Bench for the pipelined comparator: scoreboard of expected results computed
// from the masked-compare rules, plus a W=1/N=1/L=1 corner instance.
module tb_ddr4_v2_2_20_pipe_comparator;
    import ddr4_v2_2_20_cmp_pkg::*;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int NS = 6;

    typedef struct {
        logic [N-1:0] m;
        logic         any;
        logic [1:0]   idx;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   n_out  = 0;
    exp_t q[$];
    exp_t e_cmp;
    logic stall_vld = 1'b0;
    logic [N+2:0] held;

    ddr4_v2_2_20_pipe_comparator_if #(.C_DATA_WIDTH(W), .C_NUM_CH(N)) cmp ();
    ddr4_v2_2_20_pipe_comparator_if #(.C_DATA_WIDTH(1), .C_NUM_CH(1)) cmp1 ();

    ddr4_v2_2_20_pipe_comparator #(
        .C_FAMILY("virtex6"), .C_DATA_WIDTH(W), .C_NUM_CH(N), .C_LUTS_PER_STAGE(2)
    ) dut (
        .ACLK(clk), .ARESETN(rst_n), .cmp(cmp)
    );

    ddr4_v2_2_20_pipe_comparator #(
        .C_FAMILY("virtex6"), .C_DATA_WIDTH(1), .C_NUM_CH(1), .C_LUTS_PER_STAGE(1)
    ) dut1 (
        .ACLK(clk), .ARESETN(rst_n), .cmp(cmp1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    // Whole-word view: the LSB-first chain is an unsigned compare of the masked words.
    function automatic exp_t model(input logic [N*W-1:0] a, input logic [W-1:0] b,
                                   input logic [W-1:0] m, input logic [1:0] mode,
                                   input logic cin);
        exp_t e;
        logic [W-1:0] am, bm;
        logic eqc, ltc;
        e.m = '0;
        for (int k = 0; k < N; k++) begin
            am  = a[k*W +: W] & m;
            bm  = b & m;
            eqc = (am == bm) && cin;
            ltc = (am < bm) || ((am == bm) && cin);
            case (mode)
                2'd0:    e.m[k] = eqc;
                2'd1:    e.m[k] = !eqc;
                2'd2:    e.m[k] = ltc;
                default: e.m[k] = !ltc;
            endcase
        end
        e.any = |e.m;
        e.idx = '0;
        for (int k = N - 1; k >= 0; k--)
            if (e.m[k]) e.idx = 2'(k);
        return e;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic drive_rand();
        logic [W-1:0] b;
        b = W'($urandom);
        cmp.S_B    = b;
        cmp.S_MASK = ($urandom_range(0, 1) == 1) ? '1 : W'($urandom);
        cmp.S_MODE = 2'($urandom);
        cmp.S_CIN  = 1'($urandom);
        for (int k = 0; k < N; k++) begin
            case ($urandom_range(0, 2))
                0:       cmp.S_A[k*W +: W] = b;
                1:       cmp.S_A[k*W +: W] = b + W'($urandom_range(0, 2)) - W'(1);
                default: cmp.S_A[k*W +: W] = W'($urandom);
            endcase
        end
    endtask

    // Single directed request: pins the model with a literal, then the DUT result and latency.
    task automatic send(input string nm, input logic [N*W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] m, input logic [1:0] mode, input logic cin,
                        input logic [N-1:0] x_m, input logic [1:0] x_idx);
        exp_t e;
        int   lat;
        e = model(a, b, m, mode, cin);
        check({nm, "_model_match"}, e.m, x_m);
        check({nm, "_model_index"}, e.idx, x_idx);
        @(posedge clk); #1;
        cmp.S_A = a; cmp.S_B = b; cmp.S_MASK = m; cmp.S_MODE = mode; cmp.S_CIN = cin;
        cmp.S_VALID = 1'b1;
        lat = 0;
        while (!cmp.S_READY && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({nm, "_accept"}, cmp.S_READY, 1'b1);
        @(posedge clk); #1;
        cmp.S_VALID = 1'b0;
        lat = 1;
        while (!cmp.M_VALID && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        check({nm, "_latency"}, lat, NS);
        check({nm, "_match"}, cmp.M_MATCH, x_m);
        check({nm, "_any"}, cmp.M_ANY, |x_m);
        check({nm, "_index"}, cmp.M_INDEX, x_idx);
        @(posedge clk); #1;
    endtask

    // Scoreboard compare, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            stall_vld = 1'b0;
        end else begin
            if (stall_vld)
                check("hold", {cmp.M_VALID, cmp.M_MATCH, cmp.M_ANY, cmp.M_INDEX}, {1'b1, held});
            if (cmp.M_VALID && cmp.M_READY) begin
                n_out++;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got match %b expected no result", cmp.M_MATCH);
                end else begin
                    e_cmp = q.pop_front();
                    check("sb_match", cmp.M_MATCH, e_cmp.m);
                    check("sb_any", cmp.M_ANY, e_cmp.any);
                    check("sb_index", cmp.M_INDEX, e_cmp.idx);
                end
            end
            stall_vld = cmp.M_VALID && !cmp.M_READY;
            held      = {cmp.M_MATCH, cmp.M_ANY, cmp.M_INDEX};
            if (cmp.S_VALID && cmp.S_READY)
                q.push_back(model(cmp.S_A, cmp.S_B, cmp.S_MASK, cmp.S_MODE, cmp.S_CIN));
        end
    end

    // Corner instance: free-running random requests, one-cycle latency.
    logic c_pend = 1'b0;
    logic c_exp;
    initial begin
        cmp1.S_VALID = 1'b0; cmp1.S_A = '0; cmp1.S_B = '0; cmp1.S_MASK = '0;
        cmp1.S_MODE = '0; cmp1.S_CIN = 1'b0; cmp1.M_READY = 1'b1;
        forever begin
            @(posedge clk); #1;
            cmp1.S_VALID = 1'b1;
            cmp1.S_A     = 1'($urandom);
            cmp1.S_B     = 1'($urandom);
            cmp1.S_MASK  = 1'($urandom);
            cmp1.S_MODE  = 2'($urandom);
            cmp1.S_CIN   = 1'($urandom);
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            c_pend = 1'b0;
        end else begin
            if (c_pend) begin
                check("w1_valid", cmp1.M_VALID, 1'b1);
                check("w1_match", cmp1.M_MATCH, c_exp);
                check("w1_any", cmp1.M_ANY, c_exp);
                check("w1_index", cmp1.M_INDEX, 1'b0);
            end
            c_pend = cmp1.S_VALID && cmp1.S_READY;
            begin
                logic am, bm, eqc, ltc;
                am  = cmp1.S_A[0] & cmp1.S_MASK[0];
                bm  = cmp1.S_B[0] & cmp1.S_MASK[0];
                eqc = (am == bm) && cmp1.S_CIN;
                ltc = (!am && bm) || ((am == bm) && cmp1.S_CIN);
                c_exp = cmp1.S_MODE[1] ? (ltc ^ cmp1.S_MODE[0]) : (eqc ^ cmp1.S_MODE[0]);
            end
        end
    end

    initial begin
        int sent, out0;
        logic take;
        cmp.S_VALID = 1'b0; cmp.S_A = '0; cmp.S_B = '0; cmp.S_MASK = '0;
        cmp.S_MODE = '0; cmp.S_CIN = 1'b0; cmp.M_READY = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_m_valid", cmp.M_VALID, 1'b0);
        check("rst_s_ready", cmp.S_READY, 1'b0);
        check("rst_outputs", {cmp.M_MATCH, cmp.M_ANY, cmp.M_INDEX}, '0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        send("eq", {32'd9, 32'd7, 32'd7, 32'd5}, 32'd7, '1, 2'd0, 1'b1, 4'b0110, 2'd1);
        send("lt", {{3{32'h0001_0000}}, 32'h0000_FFFF}, 32'h0001_0000, '1, 2'd2, 1'b0, 4'b0001, 2'd0);
        send("ge", {{3{32'h0001_0000}}, 32'h0000_FFFF}, 32'h0001_0000, '1, 2'd3, 1'b0, 4'b1110, 2'd1);
        send("le", {{3{32'h0002_0000}}, 32'h0001_0000}, 32'h0001_0000, '1, 2'd2, 1'b1, 4'b0001, 2'd0);
        send("gt", {{3{32'h0002_0000}}, 32'h0001_0000}, 32'h0001_0000, '1, 2'd3, 1'b1, 4'b1110, 2'd1);
        send("meq", {96'd0, 32'hDEAD_BEEF}, 32'hDEAD_0000, 32'hFFFF_0000, 2'd0, 1'b1, 4'b0001, 2'd0);
        send("feq", {96'd0, 32'hDEAD_BEEF}, 32'hDEAD_0000, '1, 2'd0, 1'b1, 4'b0000, 2'd0);
        send("ne", {32'd1, 32'd7, 32'd7, 32'd7}, 32'd7, '1, 2'd1, 1'b1, 4'b1000, 2'd3);

        // Backpressure: ten back-to-back requests, result side stalled for cycles 3..12.
        sent = 0;
        out0 = n_out;
        take = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(posedge clk); #1;
            cmp.M_READY = !(cyc >= 3 && cyc <= 12);
            if (take && sent < 10) drive_rand();
            cmp.S_VALID = (sent < 10);
            @(negedge clk);
            take = cmp.S_VALID && cmp.S_READY;
            if (take) sent++;
            if (cyc == 12) begin
                check("bp_accepts", sent, 6);
                check("bp_s_ready", cmp.S_READY, 1'b0);
            end
        end
        cmp.S_VALID = 1'b0;
        check("bp_outputs", n_out - out0, 10);

        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge clk); #1;
            cmp.M_READY = ($urandom_range(0, 2) != 0);
            cmp.S_VALID = ($urandom_range(0, 3) != 0);
            drive_rand();
        end
        @(posedge clk); #1;
        cmp.S_VALID = 1'b0;
        cmp.M_READY = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("drain_empty", q.size(), 0);

        // Reset with three requests in flight and one result stalled at the output.
        cmp.M_READY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cmp.S_VALID = 1'b1;
            cmp.S_B     = W'($urandom);
            cmp.S_A     = {N{cmp.S_B}};
            cmp.S_MASK  = '1;
            cmp.S_MODE  = CMP_EQ;
            cmp.S_CIN   = 1'b1;
            @(posedge clk); #1;
        end
        cmp.S_VALID = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("pre_rst_valid", cmp.M_VALID, 1'b1);
        check("pre_rst_match", cmp.M_MATCH, 4'hF);
        rst_n = 1'b0;
        #1;
        check("arst_m_valid", cmp.M_VALID, 1'b0);
        check("arst_outputs", {cmp.M_MATCH, cmp.M_ANY, cmp.M_INDEX}, '0);
        check("arst_s_ready", cmp.S_READY, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        cmp.M_READY = 1'b1;
        @(negedge clk);
        check("rel_s_ready0", cmp.S_READY, 1'b0);
        @(negedge clk);
        check("rel_s_ready1", cmp.S_READY, 1'b1);
        out0 = n_out;
        repeat (12) @(posedge clk);
        #1;
        check("no_ghosts", n_out - out0, 0);
        check("post_m_valid", cmp.M_VALID, 1'b0);
        check("final_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
